// File: rtl/mul_job_sched.sv
// Job scheduler for the matrix-multiply datapath. It queues operation descriptors, launches them
// one at a time, watches current_state for completion and reports a tag and error flag per job.
module mul_job_sched #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    // Handshake: a descriptor transfers on a rising edge where cmd_valid && cmd_ready are both high;
    // cmd_ready depends only on the registered occupancy, abort and rst, never on cmd_valid.
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_mode,
    input  logic [31:0]                   cmd_left,
    input  logic [31:0]                   cmd_right,
    input  logic [31:0]                   cmd_addsrc,
    input  logic [31:0]                   cmd_save,
    input  logic [10:0]                   cmd_size,
    input  logic [3:0]                    cmd_tag,
    input  logic                          abort,
    output logic [2:0]                    mem_mode,
    output logic                          calc_init,
    output logic [31:0]                   BASE_ADDR_LEFT,
    output logic [31:0]                   BASE_ADDR_RIGHT,
    output logic [31:0]                   BASE_ADDR_ADDSRC,
    output logic [31:0]                   BASE_ADDR_SAVE,
    output logic [10:0]                   MATRIX_SIZE,
    input  logic [3:0]                    current_state,
    output logic                          done_valid,
    output logic [3:0]                    done_tag,
    output logic                          done_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state
);
    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [2:0]  mode;
        logic [31:0] left;
        logic [31:0] right;
        logic [31:0] addsrc;
        logic [31:0] save;
        logic [10:0] size;
        logic [3:0]  tag;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_START, S_RUN, S_DONE
    } state_t;

    desc_t         fifo_mem [FIFO_DEPTH];
    desc_t         head, in_desc, cfg_q, cfg_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [15:0]   wd_q, wd_d, wd_inc;
    logic          err_q, err_d, done_q, done_d, calc_q, calc_d;
    logic [2:0]    mode_q, mode_d;
    logic          push, pop, timeout, in_flight;

    assign in_desc   = '{mode: cmd_mode, left: cmd_left, right: cmd_right, addsrc: cmd_addsrc,
                         save: cmd_save, size: cmd_size, tag: cmd_tag};
    assign head      = fifo_mem[rd_ptr_q];
    assign cmd_ready = !rst && !abort && (count_q < CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign in_flight = (state_q == S_LAUNCH) || (state_q == S_WAIT_START) || (state_q == S_RUN);

    // The watchdog saturates, and counts from the cycle after LAUNCH.
    assign wd_inc  = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
    assign timeout = (wd_inc >= TMO);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        wd_d    = wd_q;
        err_d   = err_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            if (in_flight) begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((count_q != '0) && (current_state == 4'd0)) begin
                        pop   = 1'b1;
                        cfg_d = head;
                        if ((head.mode != 3'd0) && (head.mode <= 3'd4)) begin
                            state_d = S_LAUNCH;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    wd_d    = 16'd0;
                    state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    wd_d = wd_inc;
                    if (current_state != 4'd0) begin
                        state_d = S_RUN;
                    end else if (timeout) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
                S_RUN: begin
                    wd_d = wd_inc;
                    if (current_state == 4'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                    end else if (timeout) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        // Datapath controls are registered, so they are derived from the next state.
        mode_d = ((state_d == S_LAUNCH) || (state_d == S_WAIT_START) || (state_d == S_RUN))
                 ? cfg_d.mode : 3'd0;
        calc_d = (state_d == S_LAUNCH);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_desc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cfg_q    <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            calc_q   <= 1'b0;
            mode_q   <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            done_q   <= done_d;
            calc_q   <= calc_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign mem_mode         = mode_q;
    assign calc_init        = calc_q;
    assign BASE_ADDR_LEFT   = cfg_q.left;
    assign BASE_ADDR_RIGHT  = cfg_q.right;
    assign BASE_ADDR_ADDSRC = cfg_q.addsrc;
    assign BASE_ADDR_SAVE   = cfg_q.save;
    assign MATRIX_SIZE      = cfg_q.size;
    assign done_valid       = done_q;
    assign done_tag         = cfg_q.tag;
    assign done_err         = err_q;
    assign busy             = in_flight;
    assign fifo_count       = count_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_mul_job_sched.sv
// Bench for mul_job_sched: directed jobs against a queue-based job model checked every cycle,
// plus literal expectations for latencies, tags and boundary behaviour.
module tb_mul_job_sched;
    localparam int DEPTH = 4;
    localparam int TMO   = 32;

    typedef struct packed {
        logic [2:0]  mode;
        logic [31:0] left;
        logic [31:0] right;
        logic [31:0] addsrc;
        logic [31:0] save;
        logic [10:0] size;
        logic [3:0]  tag;
    } d_t;

    logic        clk, rst, cmd_valid, cmd_ready, abort, calc_init;
    logic [2:0]  cmd_mode, mem_mode, fifo_count, dbg_state;
    logic [31:0] cmd_left, cmd_right, cmd_addsrc, cmd_save;
    logic [31:0] BASE_ADDR_LEFT, BASE_ADDR_RIGHT, BASE_ADDR_ADDSRC, BASE_ADDR_SAVE;
    logic [10:0] cmd_size, MATRIX_SIZE;
    logic [3:0]  cmd_tag, current_state, done_tag;
    logic        done_valid, done_err, busy;

    mul_job_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_left(cmd_left), .cmd_right(cmd_right),
        .cmd_addsrc(cmd_addsrc), .cmd_save(cmd_save), .cmd_size(cmd_size), .cmd_tag(cmd_tag),
        .abort(abort), .mem_mode(mem_mode), .calc_init(calc_init),
        .BASE_ADDR_LEFT(BASE_ADDR_LEFT), .BASE_ADDR_RIGHT(BASE_ADDR_RIGHT),
        .BASE_ADDR_ADDSRC(BASE_ADDR_ADDSRC), .BASE_ADDR_SAVE(BASE_ADDR_SAVE),
        .MATRIX_SIZE(MATRIX_SIZE), .current_state(current_state), .done_valid(done_valid),
        .done_tag(done_tag), .done_err(done_err), .busy(busy), .fifo_count(fifo_count),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish in time");
        $fatal(1, "bench stopped");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- job model ----------------
    d_t  exp_q[$];
    d_t  m_cfg, m_cur;
    bit  m_active, m_started, m_done_now, m_next_done, m_push;
    int  m_launch, m_age;
    logic [3:0] m_done_tag;
    logic       m_done_err;

    task automatic m_finish(input logic err);
        m_next_done = 1'b1;
        m_done_tag  = m_cfg.tag;
        m_done_err  = err;
        m_active    = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cfg      = '0;
            m_active   = 1'b0;
            m_started  = 1'b0;
            m_done_now = 1'b0;
            m_done_tag = '0;
            m_done_err = 1'b0;
        end else begin
            m_next_done = 1'b0;
            m_push      = cmd_valid && !abort && (exp_q.size() < DEPTH);
            m_cur = '{mode: cmd_mode, left: cmd_left, right: cmd_right, addsrc: cmd_addsrc,
                      save: cmd_save, size: cmd_size, tag: cmd_tag};
            if (abort) begin
                if (m_active) m_finish(1'b1);
                exp_q.delete();
            end else if (m_done_now) begin
                // completion cycle: back to idle
            end else if (m_active) begin
                if (cyc != m_launch) begin
                    m_age = cyc - m_launch;
                    if (!m_started && current_state != 0) m_started = 1'b1;
                    else if (m_started && current_state == 0) m_finish(1'b0);
                    else if (m_age >= TMO) m_finish(1'b1);
                end
            end else if (exp_q.size() > 0 && current_state == 0) begin
                m_cfg = exp_q.pop_front();
                if (m_cfg.mode >= 3'd1 && m_cfg.mode <= 3'd4) begin
                    m_active  = 1'b1;
                    m_started = 1'b0;
                    m_launch  = cyc + 1;
                end else begin
                    m_finish(1'b1);
                end
            end
            if (m_push) exp_q.push_back(m_cur);
            m_done_now = m_next_done;
        end
        cyc = cyc + 1;
    end

    // ---------------- scoreboard compare ----------------
    int calc_cnt = 0;
    int done_cnt = 0;
    int calc_log[$];
    logic [4:0] done_log[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(!rst && !abort && (exp_q.size() < DEPTH)));
            check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
            check("calc_init", 32'(calc_init), 32'(m_active && cyc == m_launch));
            check("mem_mode", 32'(mem_mode), 32'(m_active ? m_cfg.mode : 3'd0));
            check("busy", 32'(busy), 32'(m_active));
            check("done_valid", 32'(done_valid), 32'(m_done_now));
            if (m_done_now) begin
                check("done_tag", 32'(done_tag), 32'(m_done_tag));
                check("done_err", 32'(done_err), 32'(m_done_err));
            end
            check("base_left", BASE_ADDR_LEFT, m_cfg.left);
            check("base_right", BASE_ADDR_RIGHT, m_cfg.right);
            check("base_addsrc", BASE_ADDR_ADDSRC, m_cfg.addsrc);
            check("base_save", BASE_ADDR_SAVE, m_cfg.save);
            check("matrix_size", 32'(MATRIX_SIZE), 32'(m_cfg.size));
            if (calc_init) begin
                calc_cnt++;
                calc_log.push_back(cyc);
            end
            if (done_valid) begin
                done_cnt++;
                done_log.push_back({done_err, done_tag});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic d_t mk(input logic [2:0] m, input logic [31:0] l, input logic [31:0] r,
                              input logic [31:0] a, input logic [31:0] s,
                              input logic [10:0] sz, input logic [3:0] tg);
        return '{mode: m, left: l, right: r, addsrc: a, save: s, size: sz, tag: tg};
    endfunction

    // Holds the descriptor until accepted; returns at the start of the cycle after acceptance.
    task automatic push(input d_t d, input int budget, output int at);
        bit acc;
        acc = 1'b0;
        at  = -1;
        cmd_valid = 1'b1;  cmd_mode = d.mode;     cmd_left = d.left;  cmd_right = d.right;
        cmd_addsrc = d.addsrc; cmd_save = d.save; cmd_size = d.size;  cmd_tag = d.tag;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                at  = cyc;
            end
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push_accept tag=%0d not accepted within %0d cycles", d.tag, budget);
        end
    endtask

    // which: 0 = calc_init, 1 = done_valid. Returns at the negedge of the cycle it is seen.
    task automatic wait_sig(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && calc_init) || (which == 1 && done_valid)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_sig%0d not seen within %0d cycles", which, budget);
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && done_log.size() < n; i++) @(posedge clk);
        #1;
        checks++;
        if (done_log.size() < n) begin
            errors++;
            $display("FAIL done_count actual=%0d expected=%0d", done_log.size(), n);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_mem_mode"}, 32'(mem_mode), 0);
        check({pfx, "_calc_init"}, 32'(calc_init), 0);
        check({pfx, "_left"}, BASE_ADDR_LEFT, 0);
        check({pfx, "_right"}, BASE_ADDR_RIGHT, 0);
        check({pfx, "_addsrc"}, BASE_ADDR_ADDSRC, 0);
        check({pfx, "_save"}, BASE_ADDR_SAVE, 0);
        check({pfx, "_size"}, 32'(MATRIX_SIZE), 0);
        check({pfx, "_done_valid"}, 32'(done_valid), 0);
        check({pfx, "_done_tag"}, 32'(done_tag), 0);
        check({pfx, "_done_err"}, 32'(done_err), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_fifo_count"}, 32'(fifo_count), 0);
        check({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    // ---------------- directed sequence ----------------
    int t0, lc, dc, c, d0, n0;
    int pc[6];

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_left = '0; cmd_right = '0;
        cmd_addsrc = '0; cmd_save = '0; cmd_size = '0; cmd_tag = '0;
        abort = 1'b0; current_state = '0;
        @(negedge clk);
        check("ready_in_reset", 32'(cmd_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst0");

        // single job, datapath busy for 20 cycles
        tick();
        push(mk(3'd1, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 11'd64, 4'd5), 4, t0);
        wait_sig(0, 10, lc);
        check("single_launch_lat", 32'(lc - t0), 2);
        check("single_mode", 32'(mem_mode), 1);
        check("single_left", BASE_ADDR_LEFT, 32'h1000);
        check("single_size", 32'(MATRIX_SIZE), 64);
        tick();
        current_state = 4'd1;
        @(negedge clk);
        check("single_calc_once", 32'(calc_init), 0);
        repeat (20) tick();
        current_state = 4'd0;
        c = cyc;
        wait_sig(1, 10, dc);
        check("single_done_lat", 32'(dc - c), 1);
        check("single_done_tag", 32'(done_tag), 5);
        check("single_done_err", 32'(done_err), 0);
        repeat (3) tick();
        check("single_cfg_hold", BASE_ADDR_LEFT, 32'h1000);

        // backpressure with the datapath idle: every job times out, in order
        calc_log.delete();
        done_log.delete();
        for (int k = 0; k < 5; k++)
            push(mk(3'd1, $urandom, $urandom, $urandom, $urandom,
                    11'($urandom_range(1, 2047)), 4'(k)), 4, pc[k]);
        check("bp_back_to_back", 32'(pc[4] - pc[0]), 4);
        @(negedge clk);
        check("bp_full_count", 32'(fifo_count), 4);
        check("bp_ready_low", 32'(cmd_ready), 0);
        push(mk(3'd2, 32'hA0, 32'hB0, 32'hC0, 32'hD0, 11'd7, 4'd5), 80, pc[5]);
        check("bp_tag5_held_off", 32'(pc[5] > pc[0] + 5), 1);
        wait_log(6, 6 * (TMO + 10));
        for (int k = 0; k < 6 && k < done_log.size(); k++) begin
            check("bp_order", 32'(done_log[k][3:0]), 32'(k));
            check("bp_err", 32'(done_log[k][4]), 1);
        end
        for (int k = 1; k < 6 && k < calc_log.size(); k++)
            check("bp_launch_gap", 32'(calc_log[k] - calc_log[k-1]), 32'(TMO + 3));

        // illegal mode
        repeat (2) tick();
        n0 = calc_cnt;
        push(mk(3'd7, 32'h11, 32'h22, 32'h33, 32'h44, 11'd9, 4'd9), 4, t0);
        wait_sig(1, 10, dc);
        check("ill_done_lat", 32'(dc - t0), 2);
        check("ill_tag", 32'(done_tag), 9);
        check("ill_err", 32'(done_err), 1);
        check("ill_mem_mode", 32'(mem_mode), 0);
        tick();
        check("ill_no_calc", 32'(calc_cnt - n0), 0);

        // watchdog timeout
        repeat (2) tick();
        push(mk(3'd3, 32'h500, 32'h600, 32'h700, 32'h800, 11'd16, 4'd11), 4, t0);
        wait_sig(0, 10, lc);
        wait_sig(1, TMO + 10, dc);
        check("tmo_distance", 32'(dc - lc), 32'(TMO + 1));
        check("tmo_err", 32'(done_err), 1);
        check("tmo_tag", 32'(done_tag), 11);
        check("tmo_mem_mode", 32'(mem_mode), 0);

        // abort with the first job running and two queued
        repeat (2) tick();
        push(mk(3'd2, 32'h1, 32'h2, 32'h3, 32'h4, 11'd8, 4'd1), 4, t0);
        push(mk(3'd2, 32'h5, 32'h6, 32'h7, 32'h8, 11'd8, 4'd2), 4, pc[0]);
        push(mk(3'd2, 32'h9, 32'hA, 32'hB, 32'hC, 11'd8, 4'd3), 4, pc[1]);
        current_state = 4'd1;
        repeat (3) tick();
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        check("abort_ready_low", 32'(cmd_ready), 0);
        check("abort_pre_count", 32'(fifo_count), 2);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_done_valid", 32'(done_valid), 1);
        check("abort_done_tag", 32'(done_tag), 1);
        check("abort_done_err", 32'(done_err), 1);
        check("abort_fifo_empty", 32'(fifo_count), 0);
        check("abort_mem_mode", 32'(mem_mode), 0);
        check("abort_busy", 32'(busy), 0);
        tick();
        current_state = 4'd0;
        repeat (40) tick();
        check("abort_single_pulse", 32'(done_cnt - d0), 1);

        // reset in the middle of RUN
        push(mk(3'd4, 32'hABC, 32'hDEF, 32'h123, 32'h456, 11'd32, 4'd6), 4, t0);
        wait_sig(0, 10, lc);
        tick();
        current_state = 4'd2;
        repeat (3) tick();
        d0 = done_cnt;
        rst = 1'b1;
        current_state = 4'd0;
        @(negedge clk);
        check("midrst_ready_low", 32'(cmd_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        repeat (5) tick();
        check("midrst_no_done", 32'(done_cnt - d0), 0);
        push(mk(3'd1, 32'h7000, 32'h7100, 32'h7200, 32'h7300, 11'd5, 4'd12), 4, t0);
        wait_sig(0, 10, lc);
        check("post_rst_launch_lat", 32'(lc - t0), 2);
        check("post_rst_left", BASE_ADDR_LEFT, 32'h7000);
        wait_sig(1, TMO + 10, dc);
        check("post_rst_done_tag", 32'(done_tag), 12);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
